// File: rtl/denoised_frame_tx.sv
// denoised_frame_tx: buffers 10-bit denoised pixels, packs 4 pixels into 5 bytes
// and sends framed bytes (A5 5A frame_cnt, payload, XOR checksum) over ready/valid.
module denoised_frame_tx #(
  parameter int FIFO_DEPTH   = 64,
  parameter int FRAME_PIXELS = 16384
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [9:0]                  denoised_data,
  input  logic                        denoised_data_valid,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        tx_last,
  output logic                        overflow,
  output logic [7:0]                  frame_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(FRAME_PIXELS / 4) + 1;
  localparam logic [2:0] IDLE = 3'd0, HDR0 = 3'd1, HDR1 = 3'd2, HDR2 = 3'd3,
                         LOAD = 3'd4, PAYLOAD = 3'd5, CSUM = 3'd6;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    state;
  logic [39:0]   pack;
  logic [1:0]    pix_idx;
  logic [2:0]    byte_idx;
  logic [GW-1:0] grp;
  logic [7:0]    csum;
  logic          push, pop, hs, last_grp;
  // a full FIFO drops the pixel even if a pop frees a slot in the same cycle
  assign push     = denoised_data_valid && fifo_level < LW'(FIFO_DEPTH);
  assign pop      = state == LOAD && fifo_level != '0;
  assign hs       = tx_valid && tx_ready;
  assign last_grp = grp == GW'(FRAME_PIXELS / 4 - 1);
  always_ff @(posedge sys_clk)
    if (push) mem[wr_ptr] <= denoised_data;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr + AW'(pop);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      overflow   <= overflow | (denoised_data_valid && !push);
    end
  end
  // pixels shift in from the top so pixel k lands at bits [10k+9:10k] after 4 pops;
  // payload bytes shift out from the bottom
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      tx_last   <= 1'b0;
      frame_cnt <= 8'h00;
      csum      <= 8'h00;
      grp       <= '0;
      pix_idx   <= 2'd0;
      byte_idx  <= 3'd0;
      pack      <= '0;
    end else begin
      case (state)
        IDLE: if (fifo_level != '0) begin
          state    <= HDR0;
          tx_valid <= 1'b1;
          tx_data  <= 8'hA5;
        end
        HDR0: if (hs) begin
          state   <= HDR1;
          tx_data <= 8'h5A;
        end
        HDR1: if (hs) begin
          state   <= HDR2;
          tx_data <= frame_cnt;
        end
        HDR2: if (hs) begin
          state    <= LOAD;
          tx_valid <= 1'b0;
        end
        LOAD: if (pop) begin
          pack    <= {mem[rd_ptr], pack[39:10]};
          pix_idx <= pix_idx + 2'd1;
          if (pix_idx == 2'd3) begin
            state    <= PAYLOAD;
            tx_valid <= 1'b1;
            tx_data  <= pack[17:10];
            byte_idx <= 3'd0;
          end
        end
        PAYLOAD: if (hs) begin
          csum <= csum ^ tx_data;
          pack <= {8'h00, pack[39:8]};
          if (byte_idx != 3'd4) begin
            byte_idx <= byte_idx + 3'd1;
            tx_data  <= pack[15:8];
          end else if (last_grp) begin
            grp     <= '0;
            state   <= CSUM;
            tx_data <= csum ^ tx_data;
            tx_last <= 1'b1;
          end else begin
            grp      <= grp + GW'(1);
            state    <= LOAD;
            tx_valid <= 1'b0;
          end
        end
        CSUM: if (hs) begin
          state     <= IDLE;
          tx_valid  <= 1'b0;
          tx_last   <= 1'b0;
          frame_cnt <= frame_cnt + 8'd1;
          csum      <= 8'h00;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_denoised_frame_tx.sv
// tb_denoised_frame_tx: scoreboard bench over three parameterisations of denoised_frame_tx.
module tb_denoised_frame_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst;
  logic [9:0] din [3];
  logic       dv [3];
  logic       rdy_a = 1'b1;
  logic       rdy_b, rdy_c;
  logic       rnd = 1'b0;
  logic [7:0] da, db, dc, fca, fcb, fcc;
  logic       va, vb, vc, la, lb, lc, ova, ovb, ovc;
  logic [6:0] lva, lvc;
  logic [3:0] lvb;
  int         n_chk = 0, n_pass = 0;
  logic [8:0] sbq [$];
  logic [9:0] pxq [$];
  logic [7:0] mcs;
  int         nb [3] = '{0, 0, 0};
  logic       pv [3] = '{1'b0, 1'b0, 1'b0};
  logic       pr [3] = '{1'b0, 1'b0, 1'b0};
  logic [8:0] pd [3];

  denoised_frame_tx #(.FRAME_PIXELS(8)) u_a (
    .sys_clk(clk), .sys_rst(rst), .denoised_data(din[0]), .denoised_data_valid(dv[0]),
    .tx_data(da), .tx_valid(va), .tx_ready(rdy_a), .tx_last(la),
    .overflow(ova), .frame_cnt(fca), .fifo_level(lva));
  denoised_frame_tx #(.FIFO_DEPTH(8), .FRAME_PIXELS(16)) u_b (
    .sys_clk(clk), .sys_rst(rst), .denoised_data(din[1]), .denoised_data_valid(dv[1]),
    .tx_data(db), .tx_valid(vb), .tx_ready(rdy_b), .tx_last(lb),
    .overflow(ovb), .frame_cnt(fcb), .fifo_level(lvb));
  denoised_frame_tx u_c (
    .sys_clk(clk), .sys_rst(rst), .denoised_data(din[2]), .denoised_data_valid(dv[2]),
    .tx_data(dc), .tx_valid(vc), .tx_ready(rdy_c), .tx_last(lc),
    .overflow(ovc), .frame_cnt(fcc), .fifo_level(lvc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // one instance transmits at a time, so a single queue serves all three
  task automatic mon(input int i, input logic v, input logic r, input logic [8:0] d);
    if (rst) begin
      pv[i] = 1'b0;
      return;
    end
    if (pv[i] && !pr[i]) begin
      chk($sformatf("hold_valid%0d", i), 32'(v), 32'd1);
      chk($sformatf("hold_data%0d", i), 32'(d), 32'(pd[i]));
    end
    if (v && r) begin
      nb[i]++;
      if (sbq.size() == 0) chk($sformatf("unexpected_byte%0d", i), 32'(d), 32'hFFFF_FFFF);
      else chk($sformatf("byte%0d", i), 32'(d), 32'(sbq.pop_front()));
    end
    pv[i] = v;
    pr[i] = r;
    pd[i] = d;
  endtask

  always @(negedge clk) begin
    mon(0, va, rdy_a, {la, da});
    mon(1, vb, rdy_b, {lb, db});
    mon(2, vc, rdy_c, {lc, dc});
  end

  always @(posedge clk) begin
    #1;
    rdy_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic exp_frame(input logic [7:0] fc, input int ng, input bit cs);
    sbq.push_back(9'h0A5);
    sbq.push_back(9'h05A);
    sbq.push_back({1'b0, fc});
    mcs = 8'h00;
    for (int g = 0; g < ng; g++) begin
      logic [39:0] w;
      w = {pxq[4*g+3], pxq[4*g+2], pxq[4*g+1], pxq[4*g]};
      for (int j = 0; j < 5; j++) begin
        sbq.push_back({1'b0, w[7:0]});
        mcs ^= w[7:0];
        w = w >> 8;
      end
    end
    if (cs) sbq.push_back({1'b1, mcs});
  endtask

  task automatic drive(input int k, input int gap);
    for (int j = 0; j < pxq.size(); j++) begin
      din[k] = pxq[j];
      dv[k]  = 1'b1;
      @(posedge clk); #1;
      dv[k] = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain(input string tag, input int lim);
    int n = 0;
    while (sbq.size() != 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(tag, 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic rand_px(input int n);
    pxq.delete();
    for (int j = 0; j < n; j++) pxq.push_back(10'($urandom));
  endtask

  initial begin
    int base, n;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin din[k] = 10'd0; dv[k] = 1'b0; end
    rdy_b = 1'b0;
    rdy_c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_a", 32'(va), 0);
    chk("rst_data_a", 32'(da), 0);
    chk("rst_last_a", 32'(la), 0);
    chk("rst_ovf_a", 32'(ova), 0);
    chk("rst_fcnt_a", 32'(fca), 0);
    chk("rst_level_a", 32'(lva), 0);
    chk("rst_valid_b", 32'(vb), 0);
    chk("rst_level_b", 32'(lvb), 0);
    chk("rst_valid_c", 32'(vc), 0);
    rst = 1'b0;
    // basic frame with push-to-header latency
    pxq = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
    exp_frame(8'h00, 2, 1'b1);
    for (int j = 0; j < 8; j++) begin
      din[0] = pxq[j];
      dv[0]  = 1'b1;
      @(posedge clk); #1;
      if (j == 0) begin
        chk("lat_level", 32'(lva), 1);
        chk("lat_idle", 32'(va), 0);
      end
      if (j == 1) begin
        chk("lat_valid", 32'(va), 1);
        chk("lat_hdr", 32'(da), 32'hA5);
      end
    end
    dv[0] = 1'b0;
    drain("t1_drain", 200);
    chk("t1_fcnt", 32'(fca), 1);
    chk("t1_ovf", 32'(ova), 0);
    // same frame under random backpressure
    rnd = 1'b1;
    exp_frame(8'h01, 2, 1'b1);
    drive(0, 0);
    drain("t2_drain", 500);
    rnd = 1'b0;
    chk("t2_fcnt", 32'(fca), 2);
    // 256 frames: header counter sweeps and frame_cnt wraps
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int f = 0; f < 256; f++) begin
      rand_px(8);
      exp_frame(8'(f), 2, 1'b1);
      drive(0, 0);
      drain("t4_drain", 200);
    end
    chk("t4_fcnt_wrap", 32'(fca), 0);
    chk("t4_ovf", 32'(ova), 0);
    // reset in the middle of the payload
    rand_px(8);
    exp_frame(8'h00, 2, 1'b1);
    base = nb[0];
    drive(0, 0);
    n = 0;
    while (nb[0] < base + 4 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("t5_in_payload", 32'(nb[0] - base >= 4), 1);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    chk("t5_valid", 32'(va), 0);
    chk("t5_level", 32'(lva), 0);
    chk("t5_ovf", 32'(ova), 0);
    chk("t5_fcnt", 32'(fca), 0);
    rand_px(8);
    exp_frame(8'h00, 2, 1'b1);
    drive(0, 0);
    drain("t5_drain", 200);
    chk("t5_fcnt_after", 32'(fca), 1);
    // small FIFO saturates while the sink is stalled
    pxq.delete();
    for (int j = 0; j < 10; j++) pxq.push_back(10'(10'h100 + j * 37));
    exp_frame(8'h00, 2, 1'b0);
    for (int j = 0; j < 10; j++) begin
      din[1] = pxq[j];
      dv[1]  = 1'b1;
      @(posedge clk); #1;
      if (j == 7) begin
        chk("t3_full", 32'(lvb), 8);
        chk("t3_no_ovf", 32'(ovb), 0);
      end
      if (j == 8) begin
        chk("t3_ovf_set", 32'(ovb), 1);
        chk("t3_sat", 32'(lvb), 8);
      end
      if (j == 9) chk("t3_sat2", 32'(lvb), 8);
    end
    dv[1] = 1'b0;
    rdy_b = 1'b1;
    drain("t3_drain", 200);
    repeat (10) @(posedge clk);
    #1;
    chk("t3_stall_valid", 32'(vb), 0);
    chk("t3_stall_level", 32'(lvb), 0);
    chk("t3_ovf_sticky", 32'(ovb), 1);
    chk("t3_fcnt", 32'(fcb), 0);
    // full-size frame at default parameters
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pxq.delete();
    for (int j = 0; j < 16384; j++) pxq.push_back(10'(j));
    exp_frame(8'h00, 4096, 1'b1);
    base = nb[2];
    drive(2, 2);
    drain("t6_drain", 2000);
    chk("t6_bytes", 32'(nb[2] - base), 20484);
    chk("t6_fcnt", 32'(fcc), 1);
    chk("t6_ovf", 32'(ovc), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/denoised_frame_tx.md
Name: denoised_frame_tx

Overview:
- Downstream stage of the bilateral-filter readout path. Consumes the unthrottled 10-bit denoised_data / denoised_data_valid pixel stream.
- Buffers pixels in an internal FIFO and packs 4 pixels (40 bits) into 5 bytes.
- Emits a framed byte stream on a ready/valid interface: 3-byte header, packed payload, XOR checksum. This feeds the host link (UART/USB bridge).

Parameters:
- FIFO_DEPTH, 64, pixel FIFO depth; power of 2, minimum 8.
- FRAME_PIXELS, 16384, pixels per frame (128x128); multiple of 4.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- denoised_data  in  10  filtered pixel.
- denoised_data_valid  in  1  pixel strobe, one pixel per cycle when high, no backpressure.
- tx_data  out  8  output byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte when tx_valid && tx_ready.
- tx_last  out  1  high with the checksum byte, the final byte of a frame.
- overflow  out  1  sticky; a pixel was dropped.
- frame_cnt  out  8  number of frames fully transmitted, mod 256.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: sys_rst sampled on sys_clk. All outputs clear to 0 (tx_valid, tx_last, tx_data, overflow, frame_cnt, fifo_level). FIFO is emptied and the FSM goes to IDLE.
- Reset mid-frame: the partial frame is discarded with no checksum. The next frame starts with a fresh header and frame_cnt = 0.
- FIFO push: occurs when denoised_data_valid && fifo_level < FIFO_DEPTH.
- FIFO full: if denoised_data_valid && fifo_level == FIFO_DEPTH, the pixel is dropped, even if a pop happens in the same cycle. overflow is set and stays at 1 until reset.
- Frame alignment after a drop: not resynchronised. Byte and pixel counts continue, so the frame completes late.
- FIFO pop and push in the same cycle leave the level unchanged. fifo_level is registered.
- FSM states: IDLE, HDR0, HDR1, HDR2, LOAD, PAYLOAD, CSUM.
  - IDLE: tx_valid=0. Go to HDR0 when fifo_level != 0.
  - HDR0 / HDR1 / HDR2: drive 0xA5, then 0x5A, then frame_cnt. Advance on each handshake.
  - LOAD: pop one pixel per cycle while FIFO is non-empty; stall while empty. Pixel k (k = 0..3) goes to packer bits [10k+9:10k]. After the 4th pop, go to PAYLOAD. tx_valid=0 in LOAD.
  - PAYLOAD: emit packer bytes LSB first, bits [7:0] through [39:32]. Advance one byte per handshake. After the 5th byte: go to CSUM if FRAME_PIXELS/4 groups have been sent, otherwise go to LOAD.
  - CSUM: tx_data is the XOR of all payload bytes of the frame (header excluded), with tx_last=1. On handshake: frame_cnt increments (255 wraps to 0), the checksum accumulator clears, and the FSM goes to IDLE.
- Latency: the first push at cycle N gives fifo_level=1 at N+1. HDR0 is presented (tx_valid=1, tx_data=0xA5) at N+2.
- Handshake rules:
  - tx_data and tx_last are registered outputs.
  - While tx_valid && !tx_ready, tx_valid, tx_data and tx_last hold stable.
  - tx_valid never drops before acceptance.
  - tx_valid may be asserted independent of tx_ready.
- Frame length: 3 + FRAME_PIXELS*10/8 + 1 bytes (20484 at the default).
- Counters:
  - Group counter width is $clog2(FRAME_PIXELS/4)+1.
  - Checksum is an 8-bit XOR accumulator updated on each payload handshake.

Test Plan:
- FRAME_PIXELS=8, tx_ready=1. Push pixels 0x001, 0x002, 0x003, 0x004, 0x3FF, 0x3FF, 0x3FF, 0x3FF on consecutive cycles.
  -> Bytes A5 5A 00 01 08 30 00 01 FF FF FF FF FF C7.
  -> tx_last only on C7; frame_cnt becomes 1; overflow=0.
- Same as above with tx_ready toggled pseudo-randomly (about 50%).
  -> Identical byte sequence.
  -> tx_data/tx_last never change while tx_valid && !tx_ready; no byte lost or duplicated.
- FIFO_DEPTH=8, FRAME_PIXELS=16, tx_ready=0. Push 10 pixels.
  -> fifo_level saturates at 8; overflow=1 from the cycle after the 9th push attempt.
  -> After tx_ready=1, 8 pixels are packed and the frame stalls in LOAD awaiting more pixels.
- FRAME_PIXELS=8. Send 256 back-to-back frames.
  -> Header byte 3 goes 00..FF; frame_cnt wraps to 0 after frame 256.
- FRAME_PIXELS=8. Assert sys_rst for 1 cycle mid-PAYLOAD, then push 8 new pixels.
  -> The cycle after reset: tx_valid=0, fifo_level=0, overflow=0, frame_cnt=0.
  -> The new frame starts with A5 5A 00.
- Default parameters, tx_ready=1. One 16384-pixel frame with pixel value = index[9:0].
  -> 20484 bytes; checksum matches the reference model; frame_cnt=1; overflow=0.
